// File: rtl/etapa_resultado_alu_pkg.sv
// alu_pkg: shared definitions for the ALU result stage.
//   - alucontrol encodings (SUMA/RESTA/AND/OR)
//   - flag bit positions inside a packed {N,Z,C,V} nibble
//   - entrada_resultado_t: one buffered entry at the default widths
//   - empaquetar_banderas(): builds the {N,Z,C,V} nibble from loose flags
package alu_pkg;

    localparam int RES_W  = 32;
    localparam int DEST_W = 5;
    localparam int BAN_W  = 4;

    localparam logic [1:0] SUMA  = 2'b00;
    localparam logic [1:0] RESTA = 2'b01;
    localparam logic [1:0] AND   = 2'b10;
    localparam logic [1:0] OR    = 2'b11;

    localparam int BAN_N = 3;
    localparam int BAN_Z = 2;
    localparam int BAN_C = 1;
    localparam int BAN_V = 0;

    typedef struct packed {
        logic [RES_W-1:0]  resultado;
        logic [DEST_W-1:0] destino;
        logic [BAN_W-1:0]  banderas;
    } entrada_resultado_t;

    function automatic logic [BAN_W-1:0] empaquetar_banderas(
        input logic n, input logic z, input logic c, input logic v);
        logic [BAN_W-1:0] b;
        b        = '0;
        b[BAN_N] = n;
        b[BAN_Z] = z;
        b[BAN_C] = c;
        b[BAN_V] = v;
        return b;
    endfunction

endpackage

// File: rtl/etapa_resultado_alu_if.sv
// Bus between the ALU, the result stage and writeback.
//   slave  : seen by the stage (takes ALU inputs and salida_lista, drives the rest)
//   master : seen by the environment (ALU + writeback side)
interface etapa_resultado_alu_if #(
    parameter int n          = 32,
    parameter int ANCHO_DEST = 5
);
    logic                  entrada_valida;
    logic                  entrada_lista;
    logic [n-1:0]          resultado;
    logic                  carry;
    logic                  cero;
    logic                  negativo;
    logic                  desbordamiento;
    logic [ANCHO_DEST-1:0] destino;
    logic                  actualizar_banderas;
    logic                  vaciar;
    logic                  salida_valida;
    logic                  salida_lista;
    logic [n-1:0]          salida_resultado;
    logic [ANCHO_DEST-1:0] salida_destino;
    logic [3:0]            salida_banderas;
    logic [3:0]            banderas;
    logic [1:0]            ocupacion;

    modport slave (
        input  entrada_valida, resultado, carry, cero, negativo, desbordamiento,
               destino, actualizar_banderas, vaciar, salida_lista,
        output entrada_lista, salida_valida, salida_resultado, salida_destino,
               salida_banderas, banderas, ocupacion
    );

    modport master (
        output entrada_valida, resultado, carry, cero, negativo, desbordamiento,
               destino, actualizar_banderas, vaciar, salida_lista,
        input  entrada_lista, salida_valida, salida_resultado, salida_destino,
               salida_banderas, banderas, ocupacion
    );
endinterface

// File: rtl/etapa_resultado_alu_fifo.sv
// fifo_dos_entradas: generic 2-deep synchronous FIFO.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din at the tail (ignored when full)
//   pop      : drop the head (ignored when empty)
//   flush    : empty the FIFO; beats push/pop
//   dout     : head entry (undefined content when empty)
//   cuenta   : entries held, 0..2
module fifo_dos_entradas #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [ANCHO-1:0] din,
    output logic [ANCHO-1:0] dout,
    output logic [1:0]       cuenta
);
    logic [ANCHO-1:0] mem_q [2];
    logic [ANCHO-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cuenta_q, cuenta_d;
    logic             push_ok, pop_ok;

    assign push_ok = push && (cuenta_q != 2'd2);
    assign pop_ok  = pop  && (cuenta_q != 2'd0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cuenta_d = cuenta_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cuenta_d = 2'd0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop_ok)
                rd_ptr_d = ~rd_ptr_q;
            cuenta_d = cuenta_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cuenta_q <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cuenta_q <= cuenta_d;
        end
    end

    // Storage needs no reset: cuenta gates whether it is ever observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout   = mem_q[rd_ptr_q];
    assign cuenta = cuenta_q;

endmodule

// File: rtl/etapa_resultado_alu.sv
// etapa_resultado_alu: execute-to-writeback stage behind the ALU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of etapa_resultado_alu_if
//              in : entrada_valida, resultado, flags, destino, actualizar_banderas,
//                   vaciar, salida_lista
//              out: entrada_lista, salida_* head entry, banderas (NZCV), ocupacion
// ALU results are queued in a 2-entry FIFO and handed to writeback in order.
// The architectural NZCV register is written when an entry is accepted.
module etapa_resultado_alu
    import alu_pkg::*;
#(
    parameter int n          = RES_W,
    parameter int ANCHO_DEST = DEST_W
) (
    input  logic                  clk,
    input  logic                  rst,
    etapa_resultado_alu_if.slave  bus
);
    typedef struct packed {
        logic [n-1:0]          resultado;
        logic [ANCHO_DEST-1:0] destino;
        logic [BAN_W-1:0]      banderas;
    } entrada_t;

    entrada_t         ent, cab;
    logic [1:0]       cuenta;
    logic             push, pop, valida;
    logic [BAN_W-1:0] flags_in;
    logic [BAN_W-1:0] banderas_q, banderas_d;

    assign flags_in = empaquetar_banderas(bus.negativo, bus.cero, bus.carry,
                                          bus.desbordamiento);

    // Ready depends only on registered occupancy, never on salida_lista, so a
    // full buffer refuses input even in a cycle where it drains.
    assign bus.entrada_lista = !rst && !bus.vaciar && (cuenta != 2'd2);
    assign push   = bus.entrada_valida && bus.entrada_lista;
    assign valida = (cuenta != 2'd0);
    assign pop    = valida && bus.salida_lista;

    assign ent.resultado = bus.resultado;
    assign ent.destino   = bus.destino;
    assign ent.banderas  = flags_in;

    fifo_dos_entradas #(
        .ANCHO ($bits(entrada_t))
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (bus.vaciar),
        .din    (ent),
        .dout   (cab),
        .cuenta (cuenta)
    );

    always_comb begin
        banderas_d = banderas_q;
        if (push && bus.actualizar_banderas)
            banderas_d = flags_in;
    end

    always_ff @(posedge clk) begin
        if (rst) banderas_q <= '0;
        else     banderas_q <= banderas_d;
    end

    // Head fields are zeroed while empty so stale storage never leaks out.
    assign bus.salida_valida    = valida;
    assign bus.salida_resultado = valida ? cab.resultado : '0;
    assign bus.salida_destino   = valida ? cab.destino   : '0;
    assign bus.salida_banderas  = valida ? cab.banderas  : '0;
    assign bus.banderas         = banderas_q;
    assign bus.ocupacion        = cuenta;

endmodule
